// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    function automatic int bit_period(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two (>= 2).
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with transmit FIFO.
// Optional clear-to-send gating is enabled with macro UART_TX_CTS_EN.
//   state  | meaning
//   IDLE   | line high, waiting for a queued word (and CTS)
//   START  | start bit (0)
//   DATA   | payload bits, LSB first
//   PARITY | optional parity bit
//   STOP   | STOP_BITS stop bits (1)
module uart_tx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 230400,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              reset,
`ifdef UART_TX_CTS_EN
    input  logic                              cts_n,
`endif
    input  logic [DATA_BITS-1:0]              TxData,
    input  logic                              doTransmit,
    output logic                              ready,
    output logic                              TxD,
    output logic                              isBusy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifoCount,
    output logic                              overflow
);
    import uart_pkg::*;

    localparam int BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int IDX_W      = $clog2(DATA_BITS);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
    localparam parity_e PAR_MODE = parity_e'(PARITY);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 ready_q, busy_q, ovf_q;

    logic                 push, pop, full, empty, cts_ok, bit_end, start_frame;
    logic [DATA_BITS-1:0] head;
    logic [CW-1:0]        count, count_nxt;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cts_sync_q <= 2'b11;
        else       cts_sync_q <= {cts_sync_q[0], cts_n};
    end

    assign cts_ok = ~cts_sync_q[1];
`else
    assign cts_ok = 1'b1;
`endif

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (TxData),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign push      = doTransmit & ready_q & ~full;
    assign bit_end   = (baud_q == CNT_LAST);
    assign count_nxt = count + CW'(push) - CW'(pop);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        txd_d       = txd_q;
        pop         = 1'b0;
        start_frame = 1'b0;

        if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!empty && cts_ok) start_frame = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        if (PAR_MODE != PAR_NONE) begin
                            txd_d   = par_q;
                            state_d = uart_pkg::PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            idx_d   = '0;
                            state_d = STOP;
                        end
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (bit_end) begin
                    txd_d   = 1'b1;
                    idx_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        // Chain straight into the next frame so queued words leave no idle gap.
                        txd_d   = 1'b1;
                        state_d = IDLE;
                        if (!empty && cts_ok) start_frame = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase

        if (start_frame) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = (^head) ^ (PAR_MODE == PAR_ODD);
            txd_d   = 1'b0;
            baud_d  = '0;
            state_d = START;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ready_q <= (count_nxt != CW'(FIFO_DEPTH));
            busy_q  <= (state_d != IDLE) || (count_nxt != '0);
            ovf_q   <= doTransmit & ~ready_q;
        end
    end

    assign TxD       = txd_q;
    assign ready     = ready_q;
    assign isBusy    = busy_q;
    assign overflow  = ovf_q;
    assign fifoCount = count;

endmodule

// File: tb/tb_uart_tx_param.sv
// Randomised self-checking bench for uart_tx_param across four configurations.
module tb_uart_tx_param;

    localparam int BP  [4] = '{434, 8, 6, 5};
    localparam int DB  [4] = '{8, 8, 8, 7};
    localparam int PM  [4] = '{0, 2, 1, 0};
    localparam int SB  [4] = '{1, 1, 1, 2};
    localparam int DEP [4] = '{16, 16, 4, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dotx;
    logic [8:0] din [4];
    wire  [3:0] txd, busy, rdy, ovf;
    wire  [4:0] cnt0, cnt1;
    wire  [2:0] cnt2;
    wire  [1:0] cnt3;
`ifdef UART_TX_CTS_EN
    logic [3:0] cts_n;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int exp_bits [$];
    int wq [$];

    always #5 clk = ~clk;

    uart_tx_param u_dut0 (
        .clk(clk), .reset(rst),
`ifdef UART_TX_CTS_EN
        .cts_n(cts_n[0]),
`endif
        .TxData(din[0][7:0]), .doTransmit(dotx[0]), .ready(rdy[0]), .TxD(txd[0]),
        .isBusy(busy[0]), .fifoCount(cnt0), .overflow(ovf[0]));

    uart_tx_param #(.CLK_FREQ(2_000_000), .PARITY(2)) u_dut1 (
        .clk(clk), .reset(rst),
`ifdef UART_TX_CTS_EN
        .cts_n(cts_n[1]),
`endif
        .TxData(din[1][7:0]), .doTransmit(dotx[1]), .ready(rdy[1]), .TxD(txd[1]),
        .isBusy(busy[1]), .fifoCount(cnt1), .overflow(ovf[1]));

    uart_tx_param #(.CLK_FREQ(1_500_000), .PARITY(1), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .reset(rst),
`ifdef UART_TX_CTS_EN
        .cts_n(cts_n[2]),
`endif
        .TxData(din[2][7:0]), .doTransmit(dotx[2]), .ready(rdy[2]), .TxD(txd[2]),
        .isBusy(busy[2]), .fifoCount(cnt2), .overflow(ovf[2]));

    uart_tx_param #(.CLK_FREQ(1_200_000), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(2)) u_dut3 (
        .clk(clk), .reset(rst),
`ifdef UART_TX_CTS_EN
        .cts_n(cts_n[3]),
`endif
        .TxData(din[3][6:0]), .doTransmit(dotx[3]), .ready(rdy[3]), .TxD(txd[3]),
        .isBusy(busy[3]), .fifoCount(cnt3), .overflow(ovf[3]));

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int get_cnt(input int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            2:       return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    // Expected line levels for one frame, one entry per bit period.
    task automatic add_frame(input int i, input int w);
        int p;
        exp_bits.push_back(0);
        for (int b = 0; b < DB[i]; b++) exp_bits.push_back((w >> b) & 1);
        if (PM[i] != 0) begin
            p = $countones(w & ((1 << DB[i]) - 1)) % 2;
            if (PM[i] == 1) p = 1 - p;
            exp_bits.push_back(p);
        end
        for (int s = 0; s < SB[i]; s++) exp_bits.push_back(1);
    endtask

    // Next negedge must be the first sample of the first expected bit.
    task automatic watch_line(input int i, input string tag, input int tail_busy);
        int b, s, agg;
        b = 0;
        while (b < exp_bits.size()) begin
            agg = -1;
            for (int c = 0; c < BP[i]; c++) begin
                @(negedge clk);
                s = int'(txd[i]);
                if (c == 0) agg = s;
                else if (s != agg) agg = 2;
                if (b == exp_bits.size() - 1 && c == BP[i] - 1)
                    chk($sformatf("%s busy_last_stop", tag), int'(busy[i]), 1);
            end
            chk($sformatf("%s bit%0d", tag, b), agg, exp_bits[b]);
            b++;
        end
        agg = -1;
        for (int c = 0; c < BP[i]; c++) begin
            @(negedge clk);
            s = int'(txd[i]);
            if (c == 0) begin
                agg = s;
                chk($sformatf("%s busy_after", tag), int'(busy[i]), tail_busy);
            end else if (s != agg) agg = 2;
        end
        chk($sformatf("%s idle_tail", tag), agg, 1);
    endtask

    // Push every word of wq on consecutive cycles; model acceptance and pops.
    task automatic stream_test(input int i, input string tag);
        int occ, next_pop, frame_len, acc, pop;
        occ       = 0;
        next_pop  = 0;
        frame_len = (1 + DB[i] + (PM[i] != 0 ? 1 : 0) + SB[i]) * BP[i];
        exp_bits.delete();
        @(negedge clk);
        fork
            begin
                for (int e = 0; e < wq.size(); e++) begin
                    chk($sformatf("%s ready%0d", tag, e), int'(rdy[i]), (occ < DEP[i]) ? 1 : 0);
                    din[i]  = 9'(wq[e]);
                    dotx[i] = 1'b1;
                    acc = (occ < DEP[i]) ? 1 : 0;
                    pop = (occ > 0 && e >= next_pop) ? 1 : 0;
                    if (pop == 1) next_pop = e + frame_len;
                    if (acc == 1) add_frame(i, wq[e]);
                    occ = occ + acc - pop;
                    @(negedge clk);
                    chk($sformatf("%s ovf%0d", tag, e), int'(ovf[i]), 1 - acc);
                    chk($sformatf("%s count%0d", tag, e), get_cnt(i), occ);
                end
                dotx[i] = 1'b0;
            end
            begin
                @(negedge clk);
                chk($sformatf("%s txd_before_start", tag), int'(txd[i]), 1);
                chk($sformatf("%s busy_on_accept", tag), int'(busy[i]), 1);
                watch_line(i, tag, 0);
            end
        join
        chk($sformatf("%s ovf_clear", tag), int'(ovf[i]), 0);
    endtask

    task automatic rand_words(input int i, input int n);
        for (int k = 0; k < n; k++) wq.push_back(int'($urandom_range((1 << DB[i]) - 1, 0)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, agg;
        rst  = 1'b1;
        dotx = '0;
        for (int i = 0; i < 4; i++) din[i] = '0;
`ifdef UART_TX_CTS_EN
        cts_n = '0;
`endif
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst%0d txd", i),   int'(txd[i]), 1);
            chk($sformatf("rst%0d busy", i),  int'(busy[i]), 0);
            chk($sformatf("rst%0d ready", i), int'(rdy[i]), 1);
            chk($sformatf("rst%0d count", i), get_cnt(i), 0);
            chk($sformatf("rst%0d ovf", i),   int'(ovf[i]), 0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Default 8N1, 434-cycle bits.
        wq = '{32'h55};
        stream_test(0, "d0_55");
        wq.delete(); rand_words(0, 1);
        stream_test(0, "d0_rand");

        // Even parity, then a burst that overflows the 16-deep FIFO.
        wq = '{32'hA5};
        stream_test(1, "d1_a5_even");
        wq.delete(); rand_words(1, 18);
        stream_test(1, "d1_burst18");

        // Odd parity, 4-deep FIFO burst.
        wq = '{32'hA5};
        stream_test(2, "d2_a5_odd");
        wq.delete(); rand_words(2, 6);
        stream_test(2, "d2_burst6");

        // 7 data bits, 2 stop bits, 2-deep FIFO.
        wq = '{32'h7F, 32'h00};
        stream_test(3, "d3_7f");
        wq.delete(); rand_words(3, 4);
        stream_test(3, "d3_burst4");

        // Reset in the middle of a frame with three words queued.
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            din[1]  = 9'($urandom_range(255, 0));
            dotx[1] = 1'b1;
            @(negedge clk);
        end
        dotx[1] = 1'b0;
        repeat (BP[1] * 3) @(negedge clk);
        chk("midrst busy_before", int'(busy[1]), 1);
        chk("midrst count_before", get_cnt(1), 3);
        #2 rst = 1'b1;
        #1;
        chk("midrst txd", int'(txd[1]), 1);
        chk("midrst count", get_cnt(1), 0);
        chk("midrst busy", int'(busy[1]), 0);
        chk("midrst ready", int'(rdy[1]), 1);
        @(negedge clk);
        rst = 1'b0;
        agg = 1;
        for (int c = 0; c < 3 * 11 * BP[1]; c++) begin
            @(negedge clk);
            s = int'(txd[1]);
            if (s != 1) agg = 0;
        end
        chk("midrst line_quiet", agg, 1);
        chk("midrst busy_after", int'(busy[1]), 0);
        chk("midrst count_after", get_cnt(1), 0);

`ifdef UART_TX_CTS_EN
        // Clear-to-send gating on the 7-bit, 2-stop configuration.
        cts_n[3] = 1'b1;
        exp_bits.delete();
        @(negedge clk);
        din[3] = 9'h2B; dotx[3] = 1'b1;
        add_frame(3, 32'h2B);
        @(negedge clk);
        din[3] = 9'h54;
        @(negedge clk);
        dotx[3] = 1'b0;
        agg = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (txd[3] !== 1'b1) agg = 0;
        end
        chk("cts held_line", agg, 1);
        chk("cts held_count", get_cnt(3), 2);
        cts_n[3] = 1'b0;
        @(negedge clk);
        chk("cts sync1", int'(txd[3]), 1);
        @(negedge clk);
        chk("cts sync2", int'(txd[3]), 1);
        fork
            watch_line(3, "cts_frame", 1);
            begin
                repeat (BP[3] * 3) @(negedge clk);
                cts_n[3] = 1'b1;
            end
        join
        chk("cts second_held", get_cnt(3), 1);
        agg = 1;
        for (int c = 0; c < 2 * BP[3]; c++) begin
            @(negedge clk);
            if (txd[3] !== 1'b1) agg = 0;
        end
        chk("cts second_line", agg, 1);
        cts_n[3] = 1'b0;
        repeat (120) @(negedge clk);
        chk("cts drained", get_cnt(3), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter: the next generation of the team's single-byte serial sender.
- Adds configurable data width, parity and stop bits.
- Adds a transmit FIFO with a valid/ready write interface, so the image-streaming logic can queue bytes back to back without polling the busy flag.
- Sits between the image-processing datapath and the board TxD pin. Default configuration is 100 MHz, 230400 baud, 8N1.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 230400, serial bit rate.
- DATA_BITS, 8, payload bits per frame. Legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits: 1 or 2.
- FIFO_DEPTH, 16, transmit FIFO entries. Must be a power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- TxData  in  DATA_BITS  word to enqueue.
- doTransmit  in  1  write strobe (valid). Accepted on a rising edge only when ready=1.
- ready  out  1  FIFO not full. Registered.
- TxD  out  1  serial line. Idles high.
- isBusy  out  1  high while the FIFO is non-empty or a frame is in progress.
- fifoCount  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- overflow  out  1  one-cycle pulse when doTransmit=1 while ready=0.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: TxD=1, isBusy=0, ready=1, fifoCount=0, overflow=0. FSM in IDLE, FIFO pointers 0, baud counter 0.
- Reset mid-frame aborts immediately. TxD returns high asynchronously and queued data is discarded.
- Bit timing:
  - BIT_PERIOD = CLK_FREQ/BAUD_RATE, integer division (434 at defaults).
  - Every bit, including start, parity and each stop bit, is held for exactly BIT_PERIOD cycles.
  - Baud counter counts 0..BIT_PERIOD-1.
- Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
  - Odd parity: XOR of the data bits, inverted.
  - Even parity: XOR of the data bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TxD=1. If the FIFO is non-empty, pop the head into the shift register, drive TxD=0, go to START.
  - START: after BIT_PERIOD cycles, drive data bit 0, go to DATA with bit index 0.
  - DATA: at each bit end, shift right. After bit DATA_BITS-1 ends, go to PARITY if PARITY!=0, else STOP.
  - PARITY: one bit period, then STOP.
  - STOP: STOP_BITS bit periods. At the end, return to IDLE.
- Latency and back-to-back framing:
  - A word accepted at edge k, with the FSM idle and the FIFO empty, drives the start bit from edge k+1.
  - IDLE evaluates the FIFO on the same edge the last stop bit ends. A queued word's start bit therefore follows the stop bit with zero idle cycles.
- FIFO:
  - Simultaneous push and pop is allowed when 0 < count < FIFO_DEPTH; fifoCount is unchanged.
  - Push while full: data dropped, overflow pulses, count unchanged.
  - No bypass path. Pop only from the FSM when the FIFO is non-empty.
  - Pointers wrap modulo FIFO_DEPTH.
- isBusy is the registered value of (FSM != IDLE) OR (count != 0). It falls on the edge the FSM enters IDLE with the FIFO empty.

Optional Feature:
- Macro: UART_TX_CTS_EN.
- When defined:
  - Adds input port cts_n (1 bit), an active-low clear-to-send from the host.
  - It passes through a 2-flop synchroniser inside the block.
  - IDLE pops and starts a frame only when the synchronised cts_n=0.
  - A frame already in progress always completes, even if cts_n rises mid-frame.
- When undefined: no port; behaviour as if cts_n is tied to 0.

Decomposition:
- Shared package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN).
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP).
  - Function bit_period(clk_freq, baud).
- One sub-module: uart_sync_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, count). It is reused later by the receiver.

Test Plan:
- Defaults, push 0x55 once -> TxD low for 434 cycles starting at edge k+1, then bits 1,0,1,0,1,0,1,0, then 1. Frame is 4340 cycles total. isBusy falls after the last stop bit.
- PARITY=2, push 0xA5 -> parity bit 0. With PARITY=1 -> parity bit 1. Frame is 11 bit periods (4774 cycles).
- DATA_BITS=7, STOP_BITS=2, push 0x7F -> 7 data ones, then two stop periods (868 cycles high) before the next start.
- Push 17 words in 17 consecutive cycles, FIFO_DEPTH=16 -> the first word pops immediately, so all 17 are accepted. An 18th push while fifoCount=16 -> overflow pulses for 1 cycle and the word is dropped. All 17 frames emitted back to back with no idle gap.
- Assert reset mid-DATA of a frame with 3 words queued -> TxD=1 and fifoCount=0 immediately. No further frames after reset is released.
- With UART_TX_CTS_EN, cts_n=1 and 2 words queued -> TxD stays high. Drop cts_n -> start bit 3 cycles later. Raise cts_n mid-frame -> the frame completes and the second word is held.
